// File: rtl/conv_pkg.sv
// conv_pkg
// Shared definitions for the convolution datapath: the PE array, its top
// level and the output-feature-map writeback stage.
//   DW         - data word width (PE partial-sum width)
//   ROWS/COLS  - output tile geometry
//   TILE_WORDS - words per output tile, emitted row-major by the array
//   wb_state_t - writeback stage state encoding
package conv_pkg;

    localparam int DW         = 16;
    localparam int ROWS       = 5;
    localparam int COLS       = 5;
    localparam int TILE_WORDS = ROWS * COLS;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        DRAIN,
        DONE
    } wb_state_t;

endpackage

// File: rtl/ofmap_writeback_if.sv
// ofmap_wr_if
// DRAM write port used by the writeback stage: one word per
// wr_valid && wr_ready cycle.
//   wr_addr  - DRAM word address
//   wr_data  - DRAM write data
//   wr_valid - write request
//   wr_ready - DRAM accepts the request this cycle
// The master modport is the requester (writeback stage) and the slave
// modport is the memory side.
interface ofmap_wr_if #(
    parameter int AW = 6,
    parameter int DW = 16
);

    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_valid;
    logic          wr_ready;

    modport master (
        output wr_addr,
        output wr_data,
        output wr_valid,
        input  wr_ready
    );

    modport slave (
        input  wr_addr,
        input  wr_data,
        input  wr_valid,
        output wr_ready
    );

endinterface

// File: rtl/ofmap_buf.sv
// ofmap_buf
// Tile buffer: DEPTH x DW register file with one synchronous write port and
// one registered read port.
//   clk, rst      - clock, asynchronous active-high reset (read register only)
//   we/waddr/wdata - write port, written on the rising edge when we=1
//   raddr         - read address, sampled every rising edge
//   rdata         - registered read data (mem[raddr] from the previous edge)
module ofmap_buf #(
    parameter int DW    = 16,
    parameter int DEPTH = conv_pkg::TILE_WORDS,
    parameter int CW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [CW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [CW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    // Storage needs no reset: every word is rewritten before it is drained.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // The read register is reset so the drain data bus is quiet after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/ofmap_writeback.sv
// ofmap_writeback
// Writeback stage behind the PE convolution array. Captures one ROWS x COLS
// output tile from the serial in_data/in_valid stream (optionally clamping
// negatives to zero), then drains it to DRAM at base_addr + index.
//   clk, rst        - clock, asynchronous active-high reset
//   start           - one-cycle pulse; arms (or restarts) tile capture
//   base_addr       - DRAM address of tile word 0, sampled with start
//   in_data/in_valid - result stream from the conv array
//   wr              - DRAM write port (master side)
//   busy            - tile capture or drain in progress
//   done            - one-cycle pulse after the last DRAM write is accepted
//   overflow        - sticky: stream word arrived while not collecting
module ofmap_writeback #(
    parameter int DW   = conv_pkg::DW,
    parameter int ROWS = conv_pkg::ROWS,
    parameter int COLS = conv_pkg::COLS,
    parameter int AW   = 6,
    parameter bit RELU = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    ofmap_wr_if.master    wr,
    output logic          busy,
    output logic          done,
    output logic          overflow
);

    import conv_pkg::*;

    localparam int            N_WORDS = ROWS * COLS;
    localparam int            CW      = $clog2(N_WORDS);
    localparam logic [CW-1:0] LAST    = CW'(N_WORDS - 1);

    wb_state_t     state;
    wb_state_t     state_next;
    logic [CW-1:0] wcnt;
    logic [CW-1:0] rcnt;
    logic [CW-1:0] rcnt_next;
    logic [AW-1:0] base;
    logic          armed;
    logic          handshake;
    logic          capture;
    logic          stray;
    logic [DW-1:0] cap_data;
    logic [DW-1:0] rd_data;

    // start always takes priority over a stream word in the same cycle, so
    // such a word is neither captured nor flagged as an overflow.
    assign handshake = (state == DRAIN) && wr.wr_ready;
    assign capture   = (state == COLLECT) && in_valid && !start;
    assign stray     = armed && in_valid && !start && (state != COLLECT);
    assign cap_data  = (RELU && in_data[DW-1]) ? '0 : in_data;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; start restarts the tile from any state.
    always_comb begin
        state_next = state;
        if (start) begin
            state_next = COLLECT;
        end else begin
            unique case (state)
                IDLE:    state_next = IDLE;
                COLLECT: if (capture && wcnt == LAST) state_next = DRAIN;
                DRAIN:   if (handshake && rcnt == LAST) state_next = DONE;
                DONE:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // The read pointer is computed one cycle ahead and fed to the buffer's
    // registered read port, so the word at rcnt is already on rd_data in the
    // first DRAIN cycle and the cycle after each handshake. It parks on the
    // last index so it never addresses past the tile.
    always_comb begin
        rcnt_next = rcnt;
        if (start) begin
            rcnt_next = '0;
        end else if (handshake && rcnt != LAST) begin
            rcnt_next = rcnt + 1'b1;
        end
    end

    // Counters, latched base address and the overflow flag. armed stays low
    // until the first start so stream noise after reset is not reported.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wcnt     <= '0;
            rcnt     <= '0;
            base     <= '0;
            armed    <= 1'b0;
            overflow <= 1'b0;
        end else if (start) begin
            wcnt     <= '0;
            rcnt     <= '0;
            base     <= base_addr;
            armed    <= 1'b1;
            overflow <= 1'b0;
        end else begin
            if (capture) begin
                wcnt <= wcnt + 1'b1;
            end
            rcnt <= rcnt_next;
            if (stray) begin
                overflow <= 1'b1;
            end
        end
    end

    ofmap_buf #(
        .DW    (DW),
        .DEPTH (N_WORDS),
        .CW    (CW)
    ) u_buf (
        .clk   (clk),
        .rst   (rst),
        .we    (capture),
        .waddr (wcnt),
        .wdata (cap_data),
        .raddr (rcnt_next),
        .rdata (rd_data)
    );

    // Outputs decode registered state only. The address adder wraps modulo
    // 2^AW by truncation.
    assign wr.wr_valid = (state == DRAIN);
    assign wr.wr_addr  = (state == DRAIN) ? base + AW'(rcnt) : '0;
    assign wr.wr_data  = (state == DRAIN) ? rd_data : '0;
    assign busy        = (state == COLLECT) || (state == DRAIN);
    assign done        = (state == DONE);

endmodule

// File: tb/tb_ofmap_writeback.sv
// tb_ofmap_writeback
// Directed bench for ofmap_writeback. Two instances share all inputs: one
// with ReLU enabled and one pass-through, each with its own DRAM port.
module tb_ofmap_writeback;

    logic        clk;
    logic        rst;
    logic        start;
    logic [5:0]  base_addr;
    logic [15:0] in_data;
    logic        in_valid;
    logic        wr_ready;
    logic        busy1, done1, ovf1;
    logic        busy0, done0, ovf0;

    int checks;
    int errors;

    logic [15:0] words [25];
    logic [15:0] exp1  [25];
    logic [15:0] exp0  [25];

    ofmap_wr_if #(.AW(6), .DW(16)) wr1 ();
    ofmap_wr_if #(.AW(6), .DW(16)) wr0 ();

    assign wr1.wr_ready = wr_ready;
    assign wr0.wr_ready = wr_ready;

    ofmap_writeback #(.DW(16), .ROWS(5), .COLS(5), .AW(6), .RELU(1'b1)) dut_relu (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .wr        (wr1),
        .busy      (busy1),
        .done      (done1),
        .overflow  (ovf1)
    );

    ofmap_writeback #(.DW(16), .ROWS(5), .COLS(5), .AW(6), .RELU(1'b0)) dut_pass (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .wr        (wr0),
        .busy      (busy0),
        .done      (done0),
        .overflow  (ovf0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_tile(input logic [5:0] base);
        start     = 1'b1;
        base_addr = base;
        step();
        start = 1'b0;
    endtask

    task automatic send_words(input int n);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = words[i];
            step();
        end
        in_valid = 1'b0;
    endtask

    // Drains one tile from both instances and checks address, data, stall
    // stability, drain length and the done pulse.
    task automatic drain_check(input string name, input logic [5:0] base, input bit rnd);
        int          k;
        int          cycles;
        bit          finished;
        bit          stalled;
        bit          hs;
        logic [5:0]  ea;
        logic [5:0]  pa1, pa0;
        logic [15:0] pd1, pd0;
        k = 0; cycles = 0; finished = 0; stalled = 0;
        pa1 = '0; pa0 = '0; pd1 = '0; pd0 = '0;
        while (!finished && cycles < 400) begin
            checks++;
            if (wr1.wr_valid !== 1'b1 || wr0.wr_valid !== 1'b1) begin
                errors++;
                $display("[TB] FAIL %s valid word %0d: relu=%b pass=%b, required 1", name, k, wr1.wr_valid, wr0.wr_valid);
            end
            checks++;
            if (done1 !== 1'b0 || done0 !== 1'b0) begin
                errors++;
                $display("[TB] FAIL %s early done word %0d: relu=%b pass=%b, required 0", name, k, done1, done0);
            end
            if (stalled) begin
                checks++;
                if (wr1.wr_addr !== pa1 || wr1.wr_data !== pd1 || wr0.wr_addr !== pa0 || wr0.wr_data !== pd0) begin
                    errors++;
                    $display("[TB] FAIL %s stall hold word %0d: relu %h/%h pass %h/%h, required relu %h/%h pass %h/%h",
                             name, k, wr1.wr_addr, wr1.wr_data, wr0.wr_addr, wr0.wr_data, pa1, pd1, pa0, pd0);
                end
            end else begin
                ea = base + 6'(k);
                checks++;
                if (wr1.wr_addr !== ea || wr1.wr_data !== exp1[k]) begin
                    errors++;
                    $display("[TB] FAIL %s relu word %0d: addr=%h data=%h, required addr=%h data=%h",
                             name, k, wr1.wr_addr, wr1.wr_data, ea, exp1[k]);
                end
                checks++;
                if (wr0.wr_addr !== ea || wr0.wr_data !== exp0[k]) begin
                    errors++;
                    $display("[TB] FAIL %s pass word %0d: addr=%h data=%h, required addr=%h data=%h",
                             name, k, wr0.wr_addr, wr0.wr_data, ea, exp0[k]);
                end
            end
            wr_ready = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
            pa1 = wr1.wr_addr; pd1 = wr1.wr_data;
            pa0 = wr0.wr_addr; pd0 = wr0.wr_data;
            hs      = wr1.wr_valid && wr_ready;
            stalled = wr1.wr_valid && !wr_ready;
            step();
            cycles++;
            if (hs) begin
                k++;
                if (k == 25) finished = 1;
            end
        end
        wr_ready = 1'b1;
        checks++;
        if (!finished) begin
            errors++;
            $display("[TB] FAIL %s drain timeout: %0d words accepted, required 25", name, k);
        end
        checks++;
        if ({done1, done0, busy1, busy0, wr1.wr_valid, wr0.wr_valid} !== 6'b110000) begin
            errors++;
            $display("[TB] FAIL %s end flags done/busy/valid: %b, required 110000",
                     name, {done1, done0, busy1, busy0, wr1.wr_valid, wr0.wr_valid});
        end
        if (!rnd) begin
            checks++;
            if (cycles != 25) begin
                errors++;
                $display("[TB] FAIL %s drain length: %0d cycles, required 25", name, cycles);
            end
        end
        step();
        checks++;
        if ({done1, done0, busy1, busy0} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL %s done pulse width: done/busy=%b, required 0000", name, {done1, done0, busy1, busy0});
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; base_addr = '0; in_data = '0; in_valid = 1'b0; wr_ready = 1'b1;
        step();
        step();
        checks++;
        if ({wr1.wr_valid, wr1.wr_addr, wr1.wr_data, busy1, done1, ovf1} !== 26'd0 ||
            {wr0.wr_valid, wr0.wr_addr, wr0.wr_data, busy0, done0, ovf0} !== 26'd0) begin
            errors++;
            $display("[TB] FAIL reset values: relu v=%b a=%h d=%h b=%b d=%b o=%b, required all 0",
                     wr1.wr_valid, wr1.wr_addr, wr1.wr_data, busy1, done1, ovf1);
        end
        #4 rst = 1'b0;
        step();
        in_valid = 1'b1;
        in_data  = 16'h1234;
        step();
        in_valid = 1'b0;
        step();
        checks++;
        if ({ovf1, ovf0, busy1, busy0, wr1.wr_valid} !== 5'b00000) begin
            errors++;
            $display("[TB] FAIL pre-start in_valid: ovf/busy/valid=%b, required 00000", {ovf1, ovf0, busy1, busy0, wr1.wr_valid});
        end
    endtask

    task automatic test_basic();
        for (int i = 0; i < 25; i++) begin
            words[i] = 16'(i + 1);
            exp1[i]  = 16'(i + 1);
            exp0[i]  = 16'(i + 1);
        end
        start_tile(6'h10);
        checks++;
        if ({busy1, busy0, wr1.wr_valid} !== 3'b110) begin
            errors++;
            $display("[TB] FAIL basic after start busy/valid: %b, required 110", {busy1, busy0, wr1.wr_valid});
        end
        send_words(25);
        checks++;
        if ({wr1.wr_valid, wr0.wr_valid} !== 2'b11) begin
            errors++;
            $display("[TB] FAIL basic valid after last capture: %b, required 11", {wr1.wr_valid, wr0.wr_valid});
        end
        drain_check("basic", 6'h10, 1'b0);
        checks++;
        if ({ovf1, ovf0} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL basic overflow: %b, required 00", {ovf1, ovf0});
        end
    endtask

    task automatic test_relu();
        for (int i = 0; i < 25; i++) begin
            words[i] = (i % 2 == 0) ? 16'h0005 : 16'hFFFB;
            exp1[i]  = (i % 2 == 0) ? 16'h0005 : 16'h0000;
            exp0[i]  = words[i];
        end
        start_tile(6'h00);
        send_words(25);
        drain_check("relu", 6'h00, 1'b0);
    endtask

    task automatic test_back_to_back_stalls();
        for (int i = 0; i < 25; i++) begin
            words[i] = 16'h1000 + 16'(i * 7);
            exp1[i]  = words[i];
            exp0[i]  = words[i];
        end
        start_tile(6'h20);
        send_words(25);
        drain_check("backpressure", 6'h20, 1'b1);
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 25; i++) begin
            words[i] = 16'h0A00 + 16'(i);
            exp1[i]  = words[i];
            exp0[i]  = words[i];
        end
        start_tile(6'h3A);
        send_words(25);
        drain_check("wrap", 6'h3A, 1'b0);
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 25; i++) begin
            words[i] = 16'h0200 + 16'(i);
            exp1[i]  = words[i];
            exp0[i]  = words[i];
        end
        start_tile(6'h08);
        send_words(25);
        wr_ready = 1'b0;
        in_valid = 1'b1;
        in_data  = 16'h7777;
        step();
        in_valid = 1'b0;
        wr_ready = 1'b1;
        checks++;
        if ({ovf1, ovf0} !== 2'b11) begin
            errors++;
            $display("[TB] FAIL overflow set in drain: %b, required 11", {ovf1, ovf0});
        end
        drain_check("overflow", 6'h08, 1'b0);
        checks++;
        if ({ovf1, ovf0} !== 2'b11) begin
            errors++;
            $display("[TB] FAIL overflow sticky in idle: %b, required 11", {ovf1, ovf0});
        end
    endtask

    task automatic test_abort();
        start_tile(6'h30);
        checks++;
        if ({ovf1, ovf0} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL overflow cleared by start: %b, required 00", {ovf1, ovf0});
        end
        for (int i = 0; i < 25; i++) words[i] = 16'h0300 + 16'(i);
        send_words(10);
        start     = 1'b1;
        base_addr = 6'h01;
        in_valid  = 1'b1;
        in_data   = 16'hDEAD;
        step();
        start    = 1'b0;
        in_valid = 1'b0;
        checks++;
        if ({ovf1, ovf0, done1, done0, busy1, busy0} !== 6'b000011) begin
            errors++;
            $display("[TB] FAIL abort restart ovf/done/busy: %b, required 000011", {ovf1, ovf0, done1, done0, busy1, busy0});
        end
        for (int i = 0; i < 25; i++) begin
            words[i] = 16'h0400 + 16'(i);
            exp1[i]  = words[i];
            exp0[i]  = words[i];
        end
        send_words(25);
        drain_check("abort", 6'h01, 1'b0);
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 25; i++) words[i] = 16'h0500 + 16'(i);
        start_tile(6'h05);
        send_words(25);
        step();
        step();
        step();
        checks++;
        if (wr1.wr_addr !== 6'h08 || wr1.wr_data !== 16'h0503) begin
            errors++;
            $display("[TB] FAIL mid-drain word 3: addr=%h data=%h, required addr=08 data=0503", wr1.wr_addr, wr1.wr_data);
        end
        #3 rst = 1'b1;
        #1;
        checks++;
        if ({wr1.wr_valid, wr1.wr_addr, wr1.wr_data, busy1, done1, ovf1} !== 26'd0 ||
            {wr0.wr_valid, wr0.wr_addr, wr0.wr_data, busy0, done0, ovf0} !== 26'd0) begin
            errors++;
            $display("[TB] FAIL async reset mid-drain: relu v=%b a=%h d=%h b=%b, required all 0",
                     wr1.wr_valid, wr1.wr_addr, wr1.wr_data, busy1);
        end
        #2 rst = 1'b0;
        step();
        in_valid = 1'b1;
        in_data  = 16'h4321;
        step();
        in_valid = 1'b0;
        step();
        checks++;
        if ({busy1, busy0, wr1.wr_valid, done1, ovf1, ovf0} !== 6'b000000) begin
            errors++;
            $display("[TB] FAIL after async reset idle: busy/valid/done/ovf=%b, required 000000",
                     {busy1, busy0, wr1.wr_valid, done1, ovf1, ovf0});
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_relu();
        test_back_to_back_stalls();
        test_wrap();
        test_overflow();
        test_abort();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ofmap_writeback.md
# ofmap_writeback

Output-feature-map writeback stage directly downstream of the 3x5 PE convolution array. Collects the 25 serial 16-bit results of one 5x5 output tile from the array's DATA_OUT/VALID stream into a local buffer, optionally applies ReLU, then drains the tile to DRAM over a valid/ready write port at consecutive addresses from a programmable base. One tile per `start`; reports completion and stream-protocol errors.

## Interface
- `DW`, 16, data word width (matches PE psum width)
- `ROWS`, 5, output tile rows
- `COLS`, 5, output tile columns
- `AW`, 6, DRAM word-address width
- `RELU`, 1, 1 = clamp negative (bit DW-1 set) results to 0 on capture; 0 = pass through
- `clk`  in  1  single clock, all state on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  one-cycle pulse, issued with the conv array's `en`; arms tile capture
- `base_addr`  in  AW  DRAM address of tile word 0; sampled on `start`
- `in_data`  in  DW  result word from conv array
- `in_valid`  in  1  `in_data` qualifier, one word per asserted cycle
- `wr_addr`  out  AW  DRAM write address
- `wr_data`  out  DW  DRAM write data
- `wr_valid`  out  1  write request
- `wr_ready`  in  1  DRAM accepts write when `wr_valid && wr_ready`
- `busy`  out  1  high in COLLECT or DRAIN
- `done`  out  1  one-cycle pulse after last DRAM write accepted
- `overflow`  out  1  sticky: `in_valid` seen outside COLLECT after first `start`; cleared by `start` or `rst`

## Operation
- States: IDLE, COLLECT, DRAIN, DONE.
- IDLE: `start` -> COLLECT; latch `base_addr`; clear `wcnt`, `rcnt`, `overflow`.
- COLLECT: each `in_valid` cycle writes (ReLU'd) `in_data` to `buf[wcnt]`, `wcnt++`. Word order is row-major (index = row*COLS + col), the order the array emits. Capture of word ROWS*COLS-1 -> DRAIN.
- DRAIN: `wr_valid`=1, `wr_data`=`buf[rcnt]`, `wr_addr`=`base+rcnt` (mod 2^AW, wraps silently). On handshake `rcnt++`; handshake on last word -> DONE.
- DONE: `done`=1 for exactly one cycle -> IDLE.
- `in_valid` in IDLE (after any prior `start`), DRAIN or DONE: word dropped, `overflow` set. `in_valid` in IDLE before the first `start` since reset is ignored.
- `start` in any state (including mid-COLLECT / mid-DRAIN): aborts current tile, no `done`, restarts as from IDLE; buffer contents not cleared (overwritten).
- `start` and `in_valid` in the same cycle: `start` wins, word dropped, not counted as overflow.
- ReLU is on the stored value; no other arithmetic; no saturation.

## Timing
- Reset values: state IDLE, `wr_valid`=0, `wr_addr`=0, `wr_data`=0, `busy`=0, `done`=0, `overflow`=0, counters 0.
- All outputs registered or decoded from registered state; no combinational path from `wr_ready` or `in_valid` to any output.
- Capture: word written on the edge where `in_valid`=1; last capture edge -> `wr_valid` high the next cycle.
- `wr_addr`/`wr_data` held stable while `wr_valid && !wr_ready`; new word presented the cycle after each handshake.
- `wr_ready` held high: drain takes exactly 25 cycles; `done` the cycle after the 25th handshake; `busy` falls with `done` rising.
- Minimum `start`-to-`done`: 1 + 25 capture + 25 drain + 1 cycles.

## Structure
- Package `conv_pkg`: `DW`, `ROWS`, `COLS`, `TILE_WORDS = ROWS*COLS`, `wb_state_t` enum (IDLE, COLLECT, DRAIN, DONE); shared with conv top and PE.
- Sub-module `ofmap_buf`: TILE_WORDS x DW register file, one sync write port, one registered read port addressed by `rcnt` (prefetch so `wr_data` is valid in the first DRAIN cycle).
- Top holds FSM, counters, ReLU, address adder, overflow flag.

## Test plan
- Reset mid-DRAIN, `rst` asserted asynchronously between edges -> all outputs 0 immediately, state IDLE.
- `start`, base=0x10, 25 words 1..25, `wr_ready`=1 -> writes addr 0x10..0x28 data 1..25 in order, `done` once, `overflow`=0.
- RELU=1, words alternating 0x0005/0xFFFB -> DRAM gets 0x0005/0x0000; RELU=0 -> 0xFFFB preserved.
- `wr_ready` toggled randomly 50% -> same 25 writes, `wr_addr`/`wr_data` stable across every stall, no duplicates.
- base=0x3A -> addresses 0x3A..0x3F then 0x00..0x12 (wrap).
- 26th `in_valid` during DRAIN -> dropped, `overflow`=1 sticky until next `start`; `start` after 10 captured words -> no `done`, fresh tile of 25 drains correctly.
